// File: rtl/regfile_scheduler.sv
// Write-port scheduler and hazard scoreboard for the 32x32 register file.
// Tracks in-flight short ops and one long op, stalls issue on hazards, and arbitrates the write port.
module regfile_scheduler #(
    parameter int SHORT_LAT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issueValid,
    input  logic [4:0]  issueRs1,
    input  logic [4:0]  issueRs2,
    input  logic [4:0]  issueRd,
    input  logic        issueRdWe,
    input  logic        issueLong,
    output logic        issueStall,
    input  logic [31:0] shortData,
    input  logic        longValid,
    input  logic [31:0] longData,
    output logic        longReady,
    output logic        RegWrite,
    output logic [4:0]  WriteAddr,
    output logic [31:0] WriteData
);

    logic [SHORT_LAT-1:0] stg_v_r;
    logic [4:0]           stg_rd_r [SHORT_LAT];
    logic                 long_pend_r;
    logic                 long_we_r;
    logic [4:0]           long_rd_r;

    logic short_wb_s;
    logic long_hs_s;
    logic accept_s;
    logic rd_nz_s;
    logic raw_short_s;
    logic raw_long_s;
    logic waw_s;
    logic struct_s;

    function automatic logic src_hit(input logic [4:0] rs, input logic [4:0] rd);
        return (rs != 5'd0) && (rs == rd);
    endfunction

    // Handshake and acceptance terms shared by the stall logic and the trackers.
    always_comb begin
        short_wb_s = stg_v_r[SHORT_LAT-1];
        long_hs_s  = longValid & !short_wb_s & long_pend_r;
        rd_nz_s    = issueRdWe & (issueRd != 5'd0);
        accept_s   = issueValid & !issueStall;
    end

    // Hazard detection; the writeback stage is excluded because it forwards.
    always_comb begin
        raw_short_s = 1'b0;
        for (int i = 0; i < SHORT_LAT - 1; i++) begin
            raw_short_s = raw_short_s |
                          (stg_v_r[i] & (src_hit(issueRs1, stg_rd_r[i]) |
                                         src_hit(issueRs2, stg_rd_r[i])));
        end
        raw_long_s = long_pend_r & long_we_r & !long_hs_s &
                     (src_hit(issueRs1, long_rd_r) | src_hit(issueRs2, long_rd_r));
        waw_s      = long_pend_r & long_we_r & !long_hs_s & rd_nz_s & (issueRd == long_rd_r);
        struct_s   = issueLong & long_pend_r & !long_hs_s;
        issueStall = issueValid & (raw_short_s | raw_long_s | waw_s | struct_s);
    end

    // Write-port arbitration: the short pipeline always wins.
    always_comb begin
        longReady = !short_wb_s;
        if (short_wb_s) begin
            RegWrite  = 1'b1;
            WriteAddr = stg_rd_r[SHORT_LAT-1];
            WriteData = shortData;
        end else if (longValid & long_pend_r & long_we_r) begin
            RegWrite  = 1'b1;
            WriteAddr = long_rd_r;
            WriteData = longData;
        end else begin
            RegWrite  = 1'b0;
            WriteAddr = 5'd0;
            WriteData = 32'd0;
        end
    end

    // Short tracker: fixed-latency shift register of {valid, rd}.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SHORT_LAT; i++) begin
                stg_v_r[i]  <= 1'b0;
                stg_rd_r[i] <= 5'd0;
            end
        end else begin
            stg_v_r[0]  <= accept_s & !issueLong & rd_nz_s;
            stg_rd_r[0] <= (accept_s & !issueLong & rd_nz_s) ? issueRd : 5'd0;
            for (int i = 1; i < SHORT_LAT; i++) begin
                stg_v_r[i]  <= stg_v_r[i-1];
                stg_rd_r[i] <= stg_rd_r[i-1];
            end
        end
    end

    // Long tracker: a new long op may load in the same cycle the previous one hands off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            long_pend_r <= 1'b0;
            long_we_r   <= 1'b0;
            long_rd_r   <= 5'd0;
        end else if (accept_s & issueLong) begin
            long_pend_r <= 1'b1;
            long_we_r   <= rd_nz_s;
            long_rd_r   <= issueRd;
        end else if (long_hs_s) begin
            long_pend_r <= 1'b0;
            long_we_r   <= 1'b0;
            long_rd_r   <= 5'd0;
        end else begin
            long_pend_r <= long_pend_r;
            long_we_r   <= long_we_r;
            long_rd_r   <= long_rd_r;
        end
    end

endmodule

// File: tb/tb_regfile_scheduler.sv
// Directed bench for regfile_scheduler (SHORT_LAT=3): per-cycle vector table plus a reset sequence.
module tb_regfile_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issueValid, issueRdWe, issueLong, longValid;
    logic [4:0]  issueRs1, issueRs2, issueRd;
    logic [31:0] shortData, longData;
    logic        issueStall, longReady, RegWrite;
    logic [4:0]  WriteAddr;
    logic [31:0] WriteData;

    int checks = 0;
    int failures = 0;

    regfile_scheduler #(.SHORT_LAT(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .issueValid(issueValid), .issueRs1(issueRs1), .issueRs2(issueRs2),
        .issueRd(issueRd), .issueRdWe(issueRdWe), .issueLong(issueLong),
        .issueStall(issueStall), .shortData(shortData),
        .longValid(longValid), .longData(longData), .longReady(longReady),
        .RegWrite(RegWrite), .WriteAddr(WriteAddr), .WriteData(WriteData)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [4:0]  rs1, rs2, rd;
        logic        we, lng;
        logic [31:0] sdata;
        logic        lv;
        logic [31:0] ldata;
        logic        e_stall, e_lready, e_rw;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic iv, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic we, input logic lng,
                                input logic [31:0] sdata, input logic lv, input logic [31:0] ldata,
                                input logic e_stall, input logic e_lready, input logic e_rw,
                                input logic [4:0] e_addr, input logic [31:0] e_data);
        vec_t v;
        v.iv = iv; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.we = we; v.lng = lng;
        v.sdata = sdata; v.lv = lv; v.ldata = ldata;
        v.e_stall = e_stall; v.e_lready = e_lready; v.e_rw = e_rw;
        v.e_addr = e_addr; v.e_data = e_data;
        return v;
    endfunction

    task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=%h required=%h", name, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        issueValid = v.iv; issueRs1 = v.rs1; issueRs2 = v.rs2; issueRd = v.rd;
        issueRdWe = v.we; issueLong = v.lng; shortData = v.sdata;
        longValid = v.lv; longData = v.ldata;
    endtask

    task automatic check_outs(input int row, input logic st, input logic lr, input logic rw,
                              input logic [4:0] a, input logic [31:0] d);
        check("issueStall", row, {31'd0, issueStall}, {31'd0, st});
        check("longReady", row, {31'd0, longReady}, {31'd0, lr});
        check("RegWrite", row, {31'd0, RegWrite}, {31'd0, rw});
        check("WriteAddr", row, {27'd0, WriteAddr}, {27'd0, a});
        check("WriteData", row, WriteData, d);
    endtask

    initial begin
        vec_t idle;
        idle = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,
                  1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        drive(idle);
        rst_n = 1'b0;

        // RAW on short op: stall two cycles, accepted in writeback cycle
        vecs.push_back(mk(1, 0, 0, 5, 1, 0, 0, 0, 0,              0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 5, 0, 6, 1, 0, 0, 0, 0,              1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 5, 0, 6, 1, 0, 0, 0, 0,              1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 5, 0, 6, 1, 0, 32'h55, 0, 0,         0, 0, 1, 5, 32'h55));
        vecs.push_back(mk(0, 6, 6, 0, 0, 0, 0, 0, 0,              0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,              0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h66, 0, 0,         0, 0, 1, 6, 32'h66));
        // short writeback collides with long result
        vecs.push_back(mk(1, 0, 0, 4, 1, 1, 0, 0, 0,              0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 3, 1, 0, 0, 0, 0,              0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,              0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,              0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h11, 1, 32'h22,    0, 0, 1, 3, 32'h11));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h22,         0, 1, 1, 4, 32'h22));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h99,         0, 1, 0, 0, 0));
        // long x7: consumer and second long stall until handshake
        vecs.push_back(mk(1, 0, 0, 7, 1, 1, 0, 0, 0,              0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 7, 8, 1, 0, 0, 0, 0,              1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 10, 1, 1, 0, 0, 0,             1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0,              1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 7, 8, 1, 0, 0, 1, 32'hDEADBEEF,   0, 1, 1, 7, 32'hDEADBEEF));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,              0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,              0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h88, 0, 0,         0, 0, 1, 8, 32'h88));
        vecs.push_back(mk(1, 0, 0, 11, 1, 1, 0, 0, 0,             0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 12, 1, 1, 0, 0, 0,             1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 12, 1, 1, 0, 1, 32'hAB,        0, 1, 1, 11, 32'hAB));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'hCD,         0, 1, 1, 12, 32'hCD));
        // WAW: short rd9 waits for pending long rd9
        vecs.push_back(mk(1, 0, 0, 9, 1, 1, 0, 0, 0,              0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 9, 1, 0, 0, 0, 0,              1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 9, 1, 0, 0, 1, 32'h99,         0, 1, 1, 9, 32'h99));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,              0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,              0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h91, 0, 0,         0, 0, 1, 9, 32'h91));
        // x0 destinations never write, x0 sources never stall
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0,              0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0,              0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0,              0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h5A, 1, 32'h77,    0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h5A, 1, 32'h77,    0, 1, 0, 0, 0));

        // reset-state outputs
        repeat (2) @(negedge clk);
        check_outs(-1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check_outs(i, vecs[i].e_stall, vecs[i].e_lready, vecs[i].e_rw,
                       vecs[i].e_addr, vecs[i].e_data);
        end

        // reset mid-operation: short ops in flight and a long op pending
        @(negedge clk);
        drive(mk(1, 0, 0, 13, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        @(negedge clk);
        drive(mk(1, 0, 0, 14, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        @(negedge clk);
        drive(mk(1, 13, 14, 15, 1, 0, 32'h1234, 1, 32'h4321, 0, 1, 0, 0, 0));
        #1;
        check("pre_reset_stall", 100, {31'd0, issueStall}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs(101, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 32'h1234, 1, 32'h4321, 0, 1, 0, 0, 0));
        for (int k = 0; k < 5; k++) begin
            #1;
            check_outs(102 + k, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
